// File: rtl/movement_input.sv
// movement_input: four-button front end for game_control.
// Each raw push-button is passed through a two-flop synchroniser and a
// per-bit STABLE/CHANGING debounce machine. A registered one-cycle pulse on
// movement_o is raised the cycle after a debounced level rises.
// Optional feature: define MOVEMENT_AUTO_REPEAT_EN to build a shared repeat
// counter that re-emits the held mask every REPEAT_CYCLES cycles.
`timescale 1ns/1ps

module movement_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [3:0] btn_raw_i,
  output logic [3:0] movement_o,
  output logic [3:0] btn_level_o
);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_ONE  = CNT_W'(1);

  // Refuse to elaborate with a debounce length the counter cannot reach,
  // or a repeat interval too short to form a counter.
  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_debounce
    $error("movement_input: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("movement_input: REPEAT_CYCLES must be at least 2");
  end

  logic [3:0]       sync_q1;
  logic [3:0]       sync_q2;
  logic [3:0]       level;
  logic [3:0]       level_d;
  logic [3:0]       rise;
  db_state_t        state [4];
  logic [CNT_W-1:0] count [4];

  assign btn_level_o = level;
  assign rise        = level & ~level_d;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      sync_q1 <= 4'h0;
      sync_q2 <= 4'h0;
    end else begin
      sync_q1 <= btn_raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debounce: a new level is accepted only after it has differed
  // from the current level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= STABLE;
        count[i] <= '0;
      end
      level <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        unique case (state[i])
          STABLE: begin
            if (sync_q2[i] != level[i]) begin
              state[i] <= CHANGING;
              count[i] <= DB_ONE;
            end else begin
              count[i] <= '0;
            end
          end
          CHANGING: begin
            if (sync_q2[i] == level[i]) begin
              state[i] <= STABLE;
              count[i] <= '0;
            end else if (count[i] == DB_LAST) begin
              level[i] <= sync_q2[i];
              state[i] <= STABLE;
              count[i] <= '0;
            end else begin
              count[i] <= count[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef MOVEMENT_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_count;
  logic             rpt_fire;

  assign rpt_fire = (level != 4'h0) && (level == level_d) && (rpt_count == RPT_LAST);

  // Shared repeat timer: restarts on any level change, idles when nothing
  // is held, and wraps to zero each time it fires.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      rpt_count <= '0;
    end else if ((level != level_d) || (level == 4'h0) || rpt_fire) begin
      rpt_count <= '0;
    end else begin
      rpt_count <= rpt_count + 1'b1;
    end
  end

  // Registered pulse: rising-edge pulse merged with periodic repeats.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      level_d    <= 4'h0;
      movement_o <= 4'h0;
    end else begin
      level_d    <= level;
      movement_o <= rise | (rpt_fire ? level : 4'h0);
    end
  end
`else
  // Registered pulse: one cycle per debounced rising edge only.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      level_d    <= 4'h0;
      movement_o <= 4'h0;
    end else begin
      level_d    <= level;
      movement_o <= rise;
    end
  end
`endif

endmodule

// File: tb/tb_movement_input.sv
// Testbench for movement_input (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// The reference model keeps a per-edge history of raw inputs and accepted
// levels: a bit flips when the synchronised input (raw delayed two edges)
// has disagreed with the accepted level over the whole last
// DEBOUNCE_CYCLES edges. The pulse follows one edge after the level rises.
// Build with MOVEMENT_AUTO_REPEAT_EN defined to check the repeat feature.
`timescale 1ns/1ps

module tb_movement_input;

  localparam int DB = 4;
  localparam int RP = 8;

  logic       clk_50MHz_i    = 1'b0;
  logic       rst_async_la_i = 1'b0;
  logic [3:0] btn_raw_i      = 4'h0;
  logic [3:0] movement_o;
  logic [3:0] btn_level_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] raw_h [$];
  logic [3:0] lvl_h [$];
  int         last_change = -1;
  logic [3:0] exp_move    = 4'h0;
  logic [3:0] exp_level   = 4'h0;
  int         pulse_count = 0;
  logic [3:0] pulse_or    = 4'h0;

  always #10 clk_50MHz_i = ~clk_50MHz_i;

  movement_input #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (20),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk_50MHz_i   (clk_50MHz_i),
    .rst_async_la_i(rst_async_la_i),
    .btn_raw_i     (btn_raw_i),
    .movement_o    (movement_o),
    .btn_level_o   (btn_level_o)
  );

  function automatic logic [3:0] rawAt(int k);
    if (k < 0 || k >= raw_h.size()) return 4'h0;
    return raw_h[k];
  endfunction

  function automatic logic [3:0] lvlAt(int k);
    if (k < 0 || k >= lvl_h.size()) return 4'h0;
    return lvl_h[k];
  endfunction

  // Advance the reference model by one clock edge taken out of reset.
  task automatic modelEdge();
    int         k;
    logic [3:0] prev;
    logic [3:0] next;
    logic [3:0] s;
    logic       all_diff;
    k = raw_h.size();
    raw_h.push_back(btn_raw_i);
    prev = lvlAt(k - 1);
    next = prev;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        s = rawAt(k - j - 2);
        if (s[b] == prev[b]) all_diff = 1'b0;
      end
      if (all_diff) next[b] = ~prev[b];
    end
    exp_move = lvlAt(k - 1) & ~lvlAt(k - 2);
`ifdef MOVEMENT_AUTO_REPEAT_EN
    if (lvlAt(k - 1) != lvlAt(k - 2)) last_change = k;
    else if (lvlAt(k - 1) != 4'h0 && k > last_change && ((k - last_change) % RP) == 0)
      exp_move = exp_move | lvlAt(k - 1);
`endif
    lvl_h.push_back(next);
    exp_level = next;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (movement_o === exp_move) else begin
      errors++;
      $error("[TB] FAIL %s movement_o got %h expected %h", tag, movement_o, exp_move);
    end
    checks++;
    assert (btn_level_o === exp_level) else begin
      errors++;
      $error("[TB] FAIL %s btn_level_o got %h expected %h", tag, btn_level_o, exp_level);
    end
    if (movement_o != 4'h0) begin
      pulse_count++;
      pulse_or = pulse_or | movement_o;
    end
  endtask

  // Hold a raw pattern for a number of clock edges, checking after each.
  task automatic applyStimulus(input logic [3:0] raw, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      btn_raw_i = raw;
      @(posedge clk_50MHz_i);
      if (rst_async_la_i) modelEdge();
      #1 checkOutput(tag);
    end
  endtask

  // Assert reset between edges, check its immediate effect, hold, release.
  task automatic doReset(input logic [3:0] raw, input int cycles, input string tag);
    btn_raw_i      = raw;
    rst_async_la_i = 1'b0;
    raw_h.delete();
    lvl_h.delete();
    last_change = -1;
    exp_move    = 4'h0;
    exp_level   = 4'h0;
    #1 checkOutput(tag);
    applyStimulus(raw, cycles, tag);
    @(negedge clk_50MHz_i);
    rst_async_la_i = 1'b1;
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkMask(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  initial begin
    $display("[TB] movement_input bench start");

    // Reset with all buttons held, then release reset with buttons still down.
    pulse_count = 0; pulse_or = 4'h0;
    doReset(4'hF, 5, "reset_hold");
    applyStimulus(4'hF, 10, "reset_release");
    checkCount("reset_release_pulses", pulse_count, 1);
    checkMask("reset_release_mask", pulse_or, 4'hF);
    checkMask("reset_release_level", btn_level_o, 4'hF);
    applyStimulus(4'h0, 10, "reset_release_up");

    // Clean press of right, then release.
    pulse_count = 0; pulse_or = 4'h0;
    applyStimulus(4'h2, 12, "clean_press");
    applyStimulus(4'h0, 10, "clean_release");
    checkCount("clean_pulses", pulse_count, 1);
    checkMask("clean_mask", pulse_or, 4'h2);
    checkMask("clean_level_after", btn_level_o, 4'h0);

    // Bounce on up, toggling every 2 cycles for 20 cycles.
    pulse_count = 0; pulse_or = 4'h0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h1, 2, "bounce_hi");
      applyStimulus(4'h0, 2, "bounce_lo");
    end
    applyStimulus(4'h0, 8, "bounce_tail");
    checkCount("bounce_pulses", pulse_count, 0);

    // Right and down pressed together.
    pulse_count = 0; pulse_or = 4'h0;
    applyStimulus(4'h6, 12, "simul_press");
    applyStimulus(4'h0, 10, "simul_release");
    checkCount("simul_pulses", pulse_count, 1);
    checkMask("simul_mask", pulse_or, 4'h6);

    // Right pressed three cycles before down.
    pulse_count = 0; pulse_or = 4'h0;
    applyStimulus(4'h2, 3, "stagger_first");
    applyStimulus(4'h6, 12, "stagger_both");
    applyStimulus(4'h0, 10, "stagger_release");
    checkCount("stagger_pulses", pulse_count, 2);
    checkMask("stagger_mask", pulse_or, 4'h6);

    // Reset while left is mid-debounce, left still held afterwards.
    pulse_count = 0; pulse_or = 4'h0;
    applyStimulus(4'h8, 4, "mid_debounce");
    doReset(4'h8, 3, "mid_reset");
    checkCount("mid_reset_pulses", pulse_count, 0);
    applyStimulus(4'h8, 10, "mid_after");
    checkCount("mid_after_pulses", pulse_count, 1);
    checkMask("mid_after_mask", pulse_or, 4'h8);
    applyStimulus(4'h0, 10, "mid_release");

    // Long hold of up: one pulse, or periodic repeats when built in.
    pulse_count = 0; pulse_or = 4'h0;
    applyStimulus(4'h1, 40, "hold_up");
    applyStimulus(4'h0, 20, "hold_release");
`ifndef MOVEMENT_AUTO_REPEAT_EN
    checkCount("hold_pulses", pulse_count, 1);
`endif
    checkMask("hold_mask", pulse_or, 4'h1);

    // Random patterns with random hold lengths and occasional resets.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 29) == 0)
        doReset(4'($urandom_range(0, 15)), $urandom_range(1, 3), "rand_reset");
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 9), "random");
    end
    applyStimulus(4'h0, 12, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
